// File: rtl/mem_seq_ctrl.sv
// ============================================================================
// Module   : mem_seq_ctrl
// Purpose  : Multi-cycle fetch/data/commit sequencer that lets a single-cycle
//            CPU datapath share one variable-latency memory port.
// Options  : `define MEM_SEQ_CTRL_PERF_EN to build the retire/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_seq_ctrl #(
   parameter logic [5:0] LW_OP = 6'b100011,
   parameter logic [5:0] SW_OP = 6'b101011
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        run,
   input  logic [31:0] Iaddr,
   input  logic [31:0] Daddr,
   input  logic [31:0] Dwrite,
   input  logic        Wmem,
   output logic [31:0] Inst,
   output logic [31:0] Dread,
   output logic        En,
   output logic        busy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] inst_count,
   output logic [31:0] stall_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_DATA   = 3'd3,
      S_COMMIT = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] inst_q,  inst_d;
   logic [31:0] dread_q, dread_d;

   logic w_is_mem;
   logic w_is_load;

   assign w_is_mem  = Wmem || (inst_q[31:26] == LW_OP);
   // A store opcode never loads, even if Wmem is momentarily inconsistent.
   assign w_is_load = !Wmem && (inst_q[31:26] != SW_OP);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         inst_q  <= '0;
         dread_q <= '0;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
         dread_q <= dread_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      inst_d    = inst_q;
      dread_d   = dread_q;
      En        = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_req  = 1'b1;
            mem_addr = Iaddr;
            if (mem_ready) begin
               inst_d  = mem_rdata;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            state_d = w_is_mem ? S_DATA : S_COMMIT;
         end
         S_DATA: begin
            mem_req   = 1'b1;
            mem_we    = Wmem;
            mem_addr  = Daddr;
            mem_wdata = Dwrite;
            if (mem_ready) begin
               if (w_is_load) dread_d = mem_rdata;
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            En      = 1'b1;
            state_d = run ? S_FETCH : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign Inst  = inst_q;
   assign Dread = dread_q;
   assign busy  = (state_q != S_IDLE);

`ifdef MEM_SEQ_CTRL_PERF_EN
   logic [31:0] inst_cnt_q;
   logic [31:0] stall_cnt_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         inst_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (state_q == S_COMMIT)     inst_cnt_q  <= inst_cnt_q + 32'd1;
         if (mem_req && !mem_ready)   stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign inst_count  = inst_cnt_q;
   assign stall_count = stall_cnt_q;
`else
   assign inst_count  = '0;
   assign stall_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_seq_ctrl.sv
// ============================================================================
// Module   : tb_mem_seq_ctrl
// Purpose  : Self-checking bench for mem_seq_ctrl against a per-instruction
//            timeline model of fetch, decode, data and commit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_seq_ctrl;

   localparam logic [5:0] OP_LW = 6'b100011;
   localparam logic [5:0] OP_SW = 6'b101011;
`ifdef MEM_SEQ_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Reset, run, Wmem, mem_ready;
   logic [31:0] Iaddr, Daddr, Dwrite, mem_rdata;
   logic [31:0] Inst, Dread, mem_addr, mem_wdata, inst_count, stall_count;
   logic        En, busy, mem_req, mem_we;

   mem_seq_ctrl dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .run         (run),
      .Iaddr       (Iaddr),
      .Daddr       (Daddr),
      .Dwrite      (Dwrite),
      .Wmem        (Wmem),
      .Inst        (Inst),
      .Dread       (Dread),
      .En          (En),
      .busy        (busy),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready),
      .inst_count  (inst_count),
      .stall_count (stall_count)
   );

   always #5 Clk = ~Clk;

   int tcyc = 0;
   always @(posedge Clk) tcyc <= tcyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   // Architectural model state
   logic [31:0] m_pc, m_dread, m_icnt, m_stall;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   // Entered at the negedge of the FETCH cycle; returns at the negedge after the En edge.
   task automatic do_instr(input logic [31:0] inst, input int fw, input int dw,
                           input logic [31:0] daddr, input logic [31:0] dwr,
                           input logic [31:0] rd, input bit drop_run);
      bit is_ld, is_st, is_mem, fetch, exp_req;
      int n;
      is_ld  = (inst[31:26] == OP_LW);
      is_st  = (inst[31:26] == OP_SW);
      is_mem = is_ld || is_st;
      n      = is_mem ? fw + dw + 4 : fw + 3;
      Iaddr  = m_pc;
      Wmem   = is_st;
      Daddr  = daddr;
      Dwrite = dwr;
      if (is_ld) m_dread = rd;
      for (int c = 1; c <= n; c++) begin
         fetch   = (c <= fw + 1);
         exp_req = fetch || (is_mem && c >= fw + 3 && c <= fw + dw + 3);
         if (fetch) begin
            mem_ready = (c == fw + 1);
            mem_rdata = inst;
         end else if (exp_req) begin
            mem_ready = (c == fw + dw + 3);
            mem_rdata = is_ld ? rd : $urandom;
         end else begin
            mem_ready = 1'($urandom);
            mem_rdata = $urandom;
         end
         if (drop_run && exp_req && !fetch) run = 1'b0;
         #1;
         chkb("mem_req", mem_req, exp_req);
         chkb("mem_we", mem_we, exp_req && !fetch && is_st);
         chkb("En", En, c == n);
         chkb("busy", busy, 1'b1);
         if (exp_req) chk("mem_addr", mem_addr, fetch ? m_pc : daddr);
         if (exp_req && !fetch) chk("mem_wdata", mem_wdata, dwr);
         if (c == n) begin
            chk("Inst@En", Inst, inst);
            chk("Dread@En", Dread, m_dread);
         end
         step();
      end
      m_pc    = m_pc + 32'd4;
      m_icnt  = m_icnt + 32'd1;
      m_stall = m_stall + 32'(fw) + (is_mem ? 32'(dw) : 32'd0);
      chk("inst_count", inst_count, PERF ? m_icnt : 32'd0);
      chk("stall_count", stall_count, PERF ? m_stall : 32'd0);
   endtask

   function automatic logic [31:0] rand_inst(input int kind);
      logic [25:0] lo;
      lo = 26'($urandom);
      case (kind)
         1:       return {OP_LW, lo};
         2:       return {OP_SW, lo};
         default: return {6'd0, lo};
      endcase
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      logic [31:0] ri;
      Reset = 1'b1; run = 1'b0; Wmem = 1'b0; mem_ready = 1'b0;
      Iaddr = '0; Daddr = '0; Dwrite = '0; mem_rdata = '0;
      m_pc = '0; m_dread = '0; m_icnt = '0; m_stall = '0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      chk("rst_Inst", Inst, 32'd0);
      chk("rst_Dread", Dread, 32'd0);
      chkb("rst_En", En, 1'b0);
      chkb("rst_mem_req", mem_req, 1'b0);
      chkb("rst_mem_we", mem_we, 1'b0);
      chkb("rst_busy", busy, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_inst_count", inst_count, 32'd0);
      chk("rst_stall_count", stall_count, 32'd0);

      // R-type, load with two waits, store, then run dropped mid-load
      run = 1'b1;
      step();
      do_instr(32'h012A4020, 0, 0, 32'h0, 32'h0, 32'h0, 1'b0);
      do_instr(32'h8C880004, 0, 2, 32'h104, 32'h0, 32'hDEADBEEF, 1'b0);
      do_instr(32'hAC890000, 1, 0, 32'h200, 32'h12345678, 32'hCAFEF00D, 1'b0);
      do_instr(32'h8C8A0008, 1, 1, 32'h300, 32'h0, 32'h5A5AA5A5, 1'b1);
      #1;
      chkb("stop_busy", busy, 1'b0);
      chkb("stop_mem_req", mem_req, 1'b0);
      step();
      #1;
      chkb("idle_busy", busy, 1'b0);
      chkb("idle_En", En, 1'b0);
      run = 1'b1;
      step();
      do_instr(32'h012A4020, 0, 0, 32'h0, 32'h0, 32'h0, 1'b0);

      for (int i = 0; i < 20; i++) begin
         ri = rand_inst(int'($urandom_range(0, 2)));
         do_instr(ri, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  {$urandom} & 32'hFFFF_FFFC, $urandom, $urandom, 1'b0);
      end

      // Reset while a fetch is stalled
      Iaddr = m_pc;
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chkb("stall_fetch_req", mem_req, 1'b1);
         step();
      end
      Reset = 1'b1;
      step();
      #1;
      chkb("abort_mem_req", mem_req, 1'b0);
      chk("abort_Inst", Inst, 32'd0);
      chkb("abort_En", En, 1'b0);
      chkb("abort_busy", busy, 1'b0);
      chk("abort_Dread", Dread, 32'd0);
      Reset = 1'b0;
      run = 1'b0;
      m_pc = '0; m_dread = '0; m_icnt = '0; m_stall = '0;
      for (int i = 0; i < 5; i++) begin
         step();
         #1;
         chkb("abort_no_En", En, 1'b0);
      end
      chk("abort_inst_count", inst_count, 32'd0);

      // Ten zero-wait non-memory instructions back to back
      run = 1'b1;
      step();
      t0 = tcyc;
      for (int i = 0; i < 10; i++)
         do_instr(rand_inst(0), 0, 0, $urandom, $urandom, $urandom, 1'b0);
      chk("ten_cycles", 32'(tcyc - t0), 32'd30);
      chk("ten_inst_count", inst_count, PERF ? 32'd10 : 32'd0);
      chk("ten_stall_count", stall_count, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
